// File: rtl/register_file_if.sv
// register_file_if: write, read and debug port bundle for the register file
interface register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  RegWrite;
    logic [ADDR_WIDTH-1:0] ReadRegister1;
    logic [ADDR_WIDTH-1:0] ReadRegister2;
    logic [ADDR_WIDTH-1:0] WriteRegister;
    logic [DATA_WIDTH-1:0] WriteData;
    logic [DATA_WIDTH-1:0] ReadData1;
    logic [DATA_WIDTH-1:0] ReadData2;
    logic [ADDR_WIDTH-1:0] DebugAddr;
    logic [DATA_WIDTH-1:0] DebugData;
    logic [15:0]           WriteCount;

    modport master (
        output RegWrite, ReadRegister1, ReadRegister2, WriteRegister, WriteData, DebugAddr,
        input  ReadData1, ReadData2, DebugData, WriteCount
    );

    modport slave (
        input  RegWrite, ReadRegister1, ReadRegister2, WriteRegister, WriteData, DebugAddr,
        output ReadData1, ReadData2, DebugData, WriteCount
    );
endinterface

// File: rtl/register_file.sv
// register_file: 32x32 MIPS register file, $zero hardwired, $sp preset, optional write-to-read bypass
module register_file #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] SP_INIT    = 32'h0000_03FC,
    parameter bit                    BYPASS     = 1'b1
) (
    input logic             clock,
    input logic             reset,
    register_file_if.slave  bus
);
    localparam int ENTRIES = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [ENTRIES];
    logic [15:0]           count;
    logic                  commit;

    // a write to $zero is not a write at all: it neither changes state nor counts
    assign commit = bus.RegWrite && (bus.WriteRegister != '0);

    // storage: async clear to zero with $sp preset, then one write per edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++)
                regs[i] <= (i == 29) ? SP_INIT : '0;
        end else if (commit) begin
            regs[bus.WriteRegister] <= bus.WriteData;
        end
    end

    // committed-write counter, saturating instead of wrapping
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (commit && count != 16'hFFFF)
            count <= count + 16'd1;
    end

    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
        return (addr == '0) ? '0 :
               (BYPASS && commit && addr == bus.WriteRegister) ? bus.WriteData : regs[addr];
    endfunction

    assign bus.ReadData1  = read_port(bus.ReadRegister1);
    assign bus.ReadData2  = read_port(bus.ReadRegister2);
    assign bus.DebugData  = (bus.DebugAddr == '0) ? '0 : regs[bus.DebugAddr];
    assign bus.WriteCount = count;
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed checks of reset, write/read, $zero, bypass on/off, reset-vs-write and counter saturation
module tb_register_file;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        we    = 1'b0;
    logic [4:0]  wa    = '0;
    logic [4:0]  ra1   = '0;
    logic [4:0]  ra2   = '0;
    logic [4:0]  da    = '0;
    logic [31:0] wd    = '0;
    int          errors = 0;
    int          checks = 0;

    always #5 clock = ~clock;

    register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_byp ();
    register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_nob ();

    assign bus_byp.RegWrite      = we;
    assign bus_byp.WriteRegister = wa;
    assign bus_byp.WriteData     = wd;
    assign bus_byp.ReadRegister1 = ra1;
    assign bus_byp.ReadRegister2 = ra2;
    assign bus_byp.DebugAddr     = da;
    assign bus_nob.RegWrite      = we;
    assign bus_nob.WriteRegister = wa;
    assign bus_nob.WriteData     = wd;
    assign bus_nob.ReadRegister1 = ra1;
    assign bus_nob.ReadRegister2 = ra2;
    assign bus_nob.DebugAddr     = da;

    register_file #(.BYPASS(1'b1)) dut_byp (.clock(clock), .reset(reset), .bus(bus_byp));
    register_file #(.BYPASS(1'b0)) dut_nob (.clock(clock), .reset(reset), .bus(bus_nob));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // asynchronous reset, checked before any clock edge
        #2 reset = 1'b0;
        #1;
        da = 5'd29;
        #0.1;
        check("reset_sp_no_edge", bus_byp.DebugData, 32'h0000_03FC);
        check("reset_count_no_edge", {16'h0, bus_byp.WriteCount}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            da = i[4:0];
            #1;
            check($sformatf("reset_reg%0d", i), bus_byp.DebugData, (i == 29) ? 32'h0000_03FC : 32'h0);
        end
        @(negedge clock);
        reset = 1'b1;

        // basic writes on consecutive edges
        we = 1'b1; wa = 5'd8; wd = 32'hDEAD_BEEF;
        edge_step();
        wa = 5'd9; wd = 32'h1234_5678;
        edge_step();
        we = 1'b0; ra1 = 5'd8; ra2 = 5'd9;
        #1;
        check("read1_reg8", bus_byp.ReadData1, 32'hDEAD_BEEF);
        check("read2_reg9", bus_byp.ReadData2, 32'h1234_5678);
        check("count_after_two", {16'h0, bus_byp.WriteCount}, 32'd2);
        ra1 = 5'd9;
        #1;
        check("same_reg_port1", bus_byp.ReadData1, 32'h1234_5678);
        check("same_reg_port2", bus_byp.ReadData2, 32'h1234_5678);

        // $zero stays zero, even with bypass enabled
        we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0;
        #1;
        check("zero_no_bypass", bus_byp.ReadData1, 32'h0);
        edge_step();
        we = 1'b0;
        #1;
        check("zero_after_edge", bus_byp.ReadData1, 32'h0);
        da = 5'd0;
        #1;
        check("zero_debug", bus_byp.DebugData, 32'h0);
        check("zero_count", {16'h0, bus_byp.WriteCount}, 32'd2);

        // bypass on vs off, same-cycle read of the register being written
        we = 1'b1; wa = 5'd5; wd = 32'hA5A5_A5A5; ra1 = 5'd5; ra2 = 5'd6; da = 5'd5;
        #1;
        check("bypass_rd1", bus_byp.ReadData1, 32'hA5A5_A5A5);
        check("bypass_other_port", bus_byp.ReadData2, 32'h0);
        check("bypass_debug_old", bus_byp.DebugData, 32'h0);
        check("nobypass_rd1_old", bus_nob.ReadData1, 32'h0);
        edge_step();
        we = 1'b0;
        #1;
        check("nobypass_rd1_new", bus_nob.ReadData1, 32'hA5A5_A5A5);
        check("bypass_debug_new", bus_byp.DebugData, 32'hA5A5_A5A5);
        check("count_three", {16'h0, bus_byp.WriteCount}, 32'd3);

        // reset pulsed across an edge with a pending write to $sp
        we = 1'b1; wa = 5'd29; wd = 32'h0000_0042; da = 5'd29;
        #2 reset = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        we = 1'b0;
        #1;
        check("reset_drops_write", bus_byp.DebugData, 32'h0000_03FC);
        check("reset_clears_count", {16'h0, bus_byp.WriteCount}, 32'd0);
        da = 5'd8;
        #1;
        check("reset_clears_reg8", bus_byp.DebugData, 32'h0);

        // first edge after release commits
        we = 1'b1; wa = 5'd29; wd = 32'h0000_0042; da = 5'd29;
        edge_step();
        we = 1'b0;
        #1;
        check("first_edge_write", bus_byp.DebugData, 32'h0000_0042);
        check("first_edge_count", {16'h0, bus_byp.WriteCount}, 32'd1);

        // unknown index and data with writes disabled
        wa = 'x; wd = 'x;
        edge_step();
        #1;
        check("x_idle_reg29", bus_byp.DebugData, 32'h0000_0042);
        check("x_idle_count", {16'h0, bus_byp.WriteCount}, 32'd1);

        // saturation: 65533 + 1 + 6 committed writes starting from count 1
        we = 1'b1; wa = 5'd10;
        for (int i = 0; i < 65533; i++) begin
            wd = i;
            edge_step();
        end
        check("count_fffe", {16'h0, bus_byp.WriteCount}, 32'h0000_FFFE);
        edge_step();
        check("count_ffff", {16'h0, bus_byp.WriteCount}, 32'h0000_FFFF);
        for (int i = 0; i < 6; i++) begin
            wd = 32'hCAFE_0000 + i;
            edge_step();
        end
        we = 1'b0; da = 5'd10;
        #1;
        check("count_holds", {16'h0, bus_byp.WriteCount}, 32'h0000_FFFF);
        check("write_after_sat", bus_byp.DebugData, 32'hCAFE_0005);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry x 32-bit general-purpose register file for the simplified single-cycle MIPS core.
- Sits directly downstream of the write-back 2:1 multiplexer (ALU result vs. memory data, selected by MemtoReg); that mux output drives WriteData.
- Provides two combinational read ports to the decode/ALU side, one synchronous write port, and a debug read port for the testbench.
- $zero is hardwired to 0; $sp is initialised on reset.

Parameters:
DATA_WIDTH, 32, width of each register and of all data ports
ADDR_WIDTH, 5, register index width (2**ADDR_WIDTH entries)
SP_INIT, 32'h0000_03FC, reset value of register 29 ($sp)
BYPASS, 1, 1 = read ports return WriteData when reading the register being written this cycle; 0 = read returns stored value

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
RegWrite  input  1  write enable from main control
ReadRegister1  input  ADDR_WIDTH  rs index
ReadRegister2  input  ADDR_WIDTH  rt index
WriteRegister  input  ADDR_WIDTH  destination index (output of RegDst selection)
WriteData  input  DATA_WIDTH  write-back value (from MemtoReg mux)
ReadData1  output  DATA_WIDTH  contents of ReadRegister1
ReadData2  output  DATA_WIDTH  contents of ReadRegister2
DebugAddr  input  ADDR_WIDTH  debug read index
DebugData  output  DATA_WIDTH  contents of DebugAddr (never bypassed)
WriteCount  output  16  number of committed writes since reset, saturating

Behaviour:
- Reset (reset = 0, asynchronous, immediate, independent of clock):
  - all registers = 0, except reg 29 = SP_INIT.
  - WriteCount = 0.
  - Any write on a clock edge while reset = 0 is discarded.
- Write:
  - On a rising clock edge with reset = 1, RegWrite = 1 and WriteRegister != 0: reg[WriteRegister] <= WriteData.
  - Such a write is a committed write; WriteCount increments by 1, saturating at 16'hFFFF (no wrap).
  - WriteRegister = 0 with RegWrite = 1: no state change; WriteCount unchanged.
  - RegWrite = 0: no state change.
- Reads:
  - Purely combinational, zero latency.
  - ReadDataN = 0 whenever ReadRegisterN = 0, regardless of bypass.
  - With BYPASS = 1, RegWrite = 1 and ReadRegisterN == WriteRegister != 0: ReadDataN = WriteData (same cycle). Otherwise ReadDataN = reg[ReadRegisterN].
  - With BYPASS = 0, a read of the register being written returns the old value until after the edge.
  - Both read ports may address the same register; both return identical values.
- Debug port:
  - DebugData = reg[DebugAddr], combinational, no bypass.
  - DebugData = 0 for DebugAddr = 0.
- Timing and boundary conditions:
  - Reset released asynchronously: the first edge with reset = 1 may commit a write.
  - Reset asserted in the same cycle as a pending write: the write is lost and the reset values hold.
  - Only one write per cycle; no write-write hazard.
  - X/Z on an unused index must not corrupt state when RegWrite = 0.
- Widths: all addresses are unsigned, with no wrap beyond 2**ADDR_WIDTH-1; data is stored unmodified (no sign handling).

Test Plan:
- Reset check: assert reset = 0 mid-cycle → all regs, via DebugAddr 0..31, read 0 except reg 29 = 32'h0000_03FC; WriteCount = 0, with no clock edge required.
- Basic write/read: write reg 8 = 32'hDEAD_BEEF, reg 9 = 32'h1234_5678 on consecutive edges → ReadRegister1 = 8, ReadRegister2 = 9 returns those values; WriteCount = 2.
- $zero protection: RegWrite = 1, WriteRegister = 0, WriteData = 32'hFFFF_FFFF → ReadData1 with index 0 = 0; WriteCount unchanged.
- Bypass: BYPASS = 1, RegWrite = 1, WriteRegister = 5, WriteData = 32'hA5A5_A5A5, ReadRegister1 = 5 → ReadData1 = A5A5_A5A5 before the edge and DebugData(5) = old value. Repeat with BYPASS = 0 → ReadData1 = old value until after the edge.
- Reset mid-operation: drive a write of 32'h0000_0042 to reg 29 while pulsing reset = 0 across the edge → reg 29 = SP_INIT after the edge; write discarded.
- Saturation: force 65,540 committed writes → WriteCount = 16'hFFFF and holds.
